// File: rtl/cache_port_arbiter.sv
// Fetch/data port arbiter in front of the single-port data cache.
// Holds the grant through a miss; keeps completion and miss counters.
module cache_port_arbiter #(
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_addr,
  input  logic             i_rd_req,
  output logic [31:0]      i_rd_data,
  output logic             i_stall,
  input  logic [31:0]      d_addr,
  input  logic             d_rd_req,
  input  logic             d_wr_req,
  input  logic [31:0]      d_wr_data,
  output logic [31:0]      d_rd_data,
  output logic             d_stall,
  output logic [31:0]      c_addr,
  output logic             c_rd_req,
  output logic             c_wr_req,
  output logic [31:0]      c_wr_data,
  input  logic [31:0]      c_rd_data,
  input  logic             c_miss,
  output logic [CNT_W-1:0] i_done_cnt,
  output logic [CNT_W-1:0] d_done_cnt,
  output logic [CNT_W-1:0] miss_cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_I,
    LOCK_D
  } state_t;

  localparam bit RR = (RR_MODE != 0);
  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_gnt;
  logic             r_rsp_v;
  logic             r_rsp_sel;
  logic [31:0]      r_i_hold;
  logic [31:0]      r_d_hold;
  logic [CNT_W-1:0] r_i_done;
  logic [CNT_W-1:0] r_d_done;
  logic [CNT_W-1:0] r_miss_cyc;

  logic w_i_req;
  logic w_d_req;
  logic w_sel_i;
  logic w_sel_d;
  logic w_fwd;
  logic w_done;
  logic w_i_rsp;
  logic w_d_rsp;

  assign w_i_req = i_rd_req;
  assign w_d_req = d_rd_req | d_wr_req;

  // Port selection and next state; a lock ignores the other port.
  always_comb begin
    w_sel_i     = 1'b0;
    w_sel_d     = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      LOCK_I: w_sel_i = 1'b1;
      LOCK_D: w_sel_d = 1'b1;
      default: begin
        if (w_i_req && w_d_req) begin
          if (RR) begin
            w_sel_i = r_last_gnt;
            w_sel_d = ~r_last_gnt;
          end else begin
            w_sel_d = 1'b1;
          end
        end else begin
          w_sel_i = w_i_req;
          w_sel_d = w_d_req;
        end
      end
    endcase
    if (w_sel_i || w_sel_d) begin
      if (!c_miss)
        w_state_nxt = IDLE;
      else if (w_sel_d)
        w_state_nxt = LOCK_D;
      else
        w_state_nxt = LOCK_I;
    end
  end

  assign w_fwd  = w_sel_i | w_sel_d;
  assign w_done = w_fwd & ~c_miss;

  assign c_addr    = w_sel_i ? i_addr :
                     w_sel_d ? d_addr : 32'd0;
  assign c_rd_req  = (w_sel_i & i_rd_req) |
                     (w_sel_d & d_rd_req);
  assign c_wr_req  = w_sel_d & d_wr_req;
  assign c_wr_data = w_sel_d ? d_wr_data : 32'd0;

  assign i_stall = w_i_req & ~(w_sel_i & ~c_miss);
  assign d_stall = w_d_req & ~(w_sel_d & ~c_miss);

  assign w_i_rsp = r_rsp_v & ~r_rsp_sel;
  assign w_d_rsp = r_rsp_v & r_rsp_sel;

  assign i_rd_data = w_i_rsp ? c_rd_data : r_i_hold;
  assign d_rd_data = w_d_rsp ? c_rd_data : r_d_hold;

  assign i_done_cnt   = r_i_done;
  assign d_done_cnt   = r_d_done;
  assign miss_cyc_cnt = r_miss_cyc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Last grant and read-response tag, updated on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_rsp_v    <= 1'b0;
      r_rsp_sel  <= 1'b0;
    end else begin
      r_rsp_v <= w_done & c_rd_req;
      if (w_done) begin
        r_last_gnt <= w_sel_d;
        r_rsp_sel  <= w_sel_d;
      end
    end
  end

  // Per-port read data holds, so data outlives the cache word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_hold <= 32'd0;
      r_d_hold <= 32'd0;
    end else begin
      if (w_i_rsp) r_i_hold <= c_rd_data;
      if (w_d_rsp) r_d_hold <= c_rd_data;
    end
  end

  // Free-running performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_done   <= '0;
      r_d_done   <= '0;
      r_miss_cyc <= '0;
    end else begin
      if (w_done && w_sel_i) r_i_done <= r_i_done + ONE;
      if (w_done && w_sel_d) r_d_done <= r_d_done + ONE;
      if (w_fwd && c_miss)   r_miss_cyc <= r_miss_cyc + ONE;
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester arbiter in front of the single-port data cache, sharing it between the instruction-fetch port (read-only) and the data port (read/write). It forwards one request per cycle to the cache, locks the grant to the owner for the whole miss (swap-out/swap-in) sequence, and returns stall and read data to each requester. It also keeps completion and miss-cycle counters for the lab performance report.

## Interface
- `RR_MODE`, default 1: 1 = round-robin arbitration, 0 = fixed priority (data port wins).
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `i_addr`  in  32  fetch address
- `i_rd_req`  in  1  fetch read request
- `i_rd_data`  out  32  fetch read data
- `i_stall`  out  1  fetch request not completed this cycle
- `d_addr`  in  32  data address
- `d_rd_req`  in  1  data read request
- `d_wr_req`  in  1  data write request
- `d_wr_data`  in  32  data write word
- `d_rd_data`  out  32  data read data
- `d_stall`  out  1  data request not completed this cycle
- `c_addr`  out  32  to cache `addr`
- `c_rd_req`  out  1  to cache `rd_req`
- `c_wr_req`  out  1  to cache `wr_req`
- `c_wr_data`  out  32  to cache `wr_data`
- `c_rd_data`  in  32  from cache `rd_data`; registered there, valid 1 cycle after a hit
- `c_miss`  in  1  from cache `miss`
- `i_done_cnt`, `d_done_cnt`  out  CNT_W  completed requests per port
- `miss_cyc_cnt`  out  CNT_W  cycles with a forwarded request and `c_miss` = 1

## Operation
- **States:** IDLE, LOCK_I, LOCK_D. `last_gnt` is a 1-bit register, 0 = I and 1 = D.
- **Requests:** `i_req` = `i_rd_req`; `d_req` = `d_rd_req | d_wr_req`. Each requester holds its address, data and request stable while it is stalled.
- **IDLE select:**
  - Only one request: that port is selected.
  - Both requests, `RR_MODE` = 1: the port not equal to `last_gnt` is selected.
  - Both requests, `RR_MODE` = 0: D is selected.
  - No request: nothing is selected, all `c_*` request outputs are 0, and `c_addr` = 0.
- **Forwarding:** the selected port's addr, rd_req, wr_req and wr_data drive the `c_*` outputs combinationally. I always drives `c_wr_req` = 0.
- **Miss lock:** in IDLE, if the selection has `c_miss` = 1, the next state is LOCK_I or LOCK_D.
- **LOCK_x:** port x is forwarded regardless of the other request. The block stays in LOCK_x while `c_miss` = 1. When `c_miss` = 0, the request completes that cycle and the next state is IDLE.
- **Completion:** a completion is any cycle in which a port is forwarded and `c_miss` = 0. On completion:
  - `last_gnt` <= that port.
  - That port's done counter increments.
  - If the request was a read, `rsp_sel` <= port and `rsp_v` <= 1; otherwise `rsp_v` <= 0.
- **Stall:** `x_stall` = `x_req & ~(x forwarded & ~c_miss)`. A non-selected requesting port is stalled.
- **Read data:**
  - `x_rd_data` = `c_rd_data` when `rsp_v` and `rsp_sel` = x; otherwise it is `x_hold`.
  - `x_hold` captures `c_rd_data` in every cycle where `rsp_v` and `rsp_sel` = x, so the value persists while the other port uses the cache.
- **Counters:** free-running and wrap modulo 2^CNT_W. `miss_cyc_cnt` increments each forwarded cycle with `c_miss` = 1.
- **D with both rd and wr:** forwarded as is. The cache treats it as a read on a hit; this is not a legal requester behaviour.

## Timing
- Reset (synchronous, same `rst` as the cache):
  - State = IDLE, `last_gnt` = 1 (I wins the first contention in RR mode).
  - `rsp_v` = 0, holds = 0, all counters = 0.
  - With no requests, all outputs read 0.
- Hit latency: the request is presented and completes in cycle N with stall = 0. Read data is valid on `x_rd_data` in N+1 and is held afterwards.
- A losing port waits at least 1 cycle per hit of the winner. In RR mode, with both requesting continuously, grants alternate I, D, I, D.
- A miss holds the grant for the whole cache swap. The other port stalls throughout and is served in the cycle after the owner's completion when contention favours it.
- Request dropped while locked (illegal): the lock is held until `c_miss` = 0.
- Reset asserted mid-lock: the state returns to IDLE the next edge and no completion is counted.

## Test plan
- **Fetch alone, preloaded hit:** `i_addr` = 0x40, `i_rd_req` held 1 cycle → `i_stall` = 0, `i_rd_data` = cache word at 0x40 in the next cycle, `i_done_cnt` = 1.
- **Both ports request hits every cycle, RR_MODE = 1, 8 cycles:** grants alternate I, D, I, D; `i_done_cnt` = 4, `d_done_cnt` = 4; each stall is high exactly on the alternate cycles.
- **Same contention, RR_MODE = 0:** D completes every cycle, `i_stall` stays 1, `i_done_cnt` = 0.
- **D write miss to a dirty line while I requests:** state goes LOCK_D until `c_miss` falls; `c_addr` = `d_addr` throughout; `i_stall` = 1; I completes in the first cycle after D completes; `miss_cyc_cnt` = number of miss cycles.
- **D reads 0xAA at addr A, then I reads 0x55 at B:** `d_rd_data` stays 0xAA while I is served.
- **Reset during LOCK_I:** state = IDLE and counters = 0 the next cycle; a fresh `i_rd_req` is forwarded immediately.
